// File: rtl/coin_acceptor_frontend.sv
// coin_acceptor_frontend
// Conditions the two raw coin-slot sensors (1.00 and 0.50) for the vending FSM.
// Each sensor is synchronised (2 flops), debounced by a 4-state FSM and turned
// into one single-cycle accept pulse per physical coin. It also keeps saturating
// per-coin counts and flags a slot jam.
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous reset, active-low
//   sens_r  raw 1.00-slot sensor (async, bouncy, 1 = coin present)
//   sens_c  raw 0.50-slot sensor (async, bouncy, 1 = coin present)
//   R       one-cycle pulse per accepted 1.00 coin
//   C       one-cycle pulse per accepted 0.50 coin (never coincident with R)
//   jam     both slots debounced as pressed at the same time
//   cnt_r   saturating count of accepted 1.00 coins
//   cnt_c   saturating count of accepted 0.50 coins
module coin_acceptor_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sens_r,
  input  logic               sens_c,
  output logic               R,
  output logic               C,
  output logic               jam,
  output logic [COUNT_W-1:0] cnt_r,
  output logic [COUNT_W-1:0] cnt_c
);

  localparam int unsigned    CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StDebHi, StPressed, StDebLo} ch_state_e;

  // Channel index 0 = 1.00 slot, 1 = 0.50 slot.
  logic [1:0]      sync1_q, sync2_q;
  ch_state_e       st_q  [2];
  ch_state_e       st_d  [2];
  logic [CntW-1:0] deb_q [2];
  logic [CntW-1:0] deb_d [2];
  logic [1:0]      req;

  logic               r_q, r_d, c_q, c_d, pend_q, pend_d, jam_q, jam_d;
  logic               c_avail;
  logic [COUNT_W-1:0] cnt_r_q, cnt_r_d, cnt_c_q, cnt_c_d;

  // Debounce: a level change is accepted after DEBOUNCE_CYCLES consecutive
  // synchronised samples at the new level; the counter restarts on every state change.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      deb_d[i] = deb_q[i];
      req[i]   = 1'b0;
      unique case (st_q[i])
        StIdle: begin
          if (sync2_q[i]) begin
            st_d[i]  = StDebHi;
            deb_d[i] = CntOne;
          end
        end
        StDebHi: begin
          if (!sync2_q[i]) begin
            st_d[i]  = StIdle;
            deb_d[i] = '0;
          end else if (deb_q[i] == CntLast) begin
            st_d[i]  = StPressed;
            deb_d[i] = '0;
            req[i]   = 1'b1;
          end else begin
            deb_d[i] = deb_q[i] + CntOne;
          end
        end
        StPressed: begin
          if (!sync2_q[i]) begin
            st_d[i]  = StDebLo;
            deb_d[i] = CntOne;
          end
        end
        StDebLo: begin
          if (sync2_q[i]) begin
            st_d[i]  = StPressed;
            deb_d[i] = '0;
          end else if (deb_q[i] == CntLast) begin
            st_d[i]  = StIdle;
            deb_d[i] = '0;
          end else begin
            deb_d[i] = deb_q[i] + CntOne;
          end
        end
      endcase
    end
  end

  // R has priority; a C request that collides with R waits one cycle in pend_q.
  always_comb begin
    c_avail = req[1] | pend_q;
    r_d     = req[0];
    c_d     = ~req[0] & c_avail;
    pend_d  = req[0] & c_avail;
    jam_d   = (st_d[0] == StPressed || st_d[0] == StDebLo) &&
              (st_d[1] == StPressed || st_d[1] == StDebLo);
    cnt_r_d = cnt_r_q;
    cnt_c_d = cnt_c_q;
    if (r_d && cnt_r_q != '1) cnt_r_d = cnt_r_q + 1'b1;
    if (c_d && cnt_c_q != '1) cnt_c_d = cnt_c_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= StIdle;
        deb_q[i] <= '0;
      end
      r_q     <= 1'b0;
      c_q     <= 1'b0;
      pend_q  <= 1'b0;
      jam_q   <= 1'b0;
      cnt_r_q <= '0;
      cnt_c_q <= '0;
    end else begin
      sync1_q <= {sens_c, sens_r};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        deb_q[i] <= deb_d[i];
      end
      r_q     <= r_d;
      c_q     <= c_d;
      pend_q  <= pend_d;
      jam_q   <= jam_d;
      cnt_r_q <= cnt_r_d;
      cnt_c_q <= cnt_c_d;
    end
  end

  assign R     = r_q;
  assign C     = c_q;
  assign jam   = jam_q;
  assign cnt_r = cnt_r_q;
  assign cnt_c = cnt_c_q;

endmodule

// File: tb/tb_coin_acceptor_frontend.sv
// Bench for coin_acceptor_frontend: directed scenarios with literal expectations
// plus randomized bouncy sensors, all checked every cycle against a level-based model.
module tb_coin_acceptor_frontend;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sens_r = 1'b0;
  logic       sens_c = 1'b0;
  logic       r_o, c_o, jam_o, r2_o, c2_o, jam2_o;
  logic [7:0] cnt_r_o, cnt_c_o;
  logic [1:0] cnt_r2_o, cnt_c2_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coin_acceptor_frontend #(.DEBOUNCE_CYCLES(N), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .sens_r(sens_r), .sens_c(sens_c),
    .R(r_o), .C(c_o), .jam(jam_o), .cnt_r(cnt_r_o), .cnt_c(cnt_c_o)
  );

  coin_acceptor_frontend #(.DEBOUNCE_CYCLES(N), .COUNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .sens_r(sens_r), .sens_c(sens_c),
    .R(r2_o), .C(c2_o), .jam(jam2_o), .cnt_r(cnt_r2_o), .cnt_c(cnt_c2_o)
  );

  // Model: each channel has a debounced level that flips after N consecutive
  // synchronised samples (sensor delayed 2 edges) disagreeing with it.
  bit m_p1 [2] = '{0, 0};
  bit m_p2 [2] = '{0, 0};
  bit m_lvl[2] = '{0, 0};
  int m_run[2] = '{0, 0};
  int m_pend = 0;
  bit m_r = 0, m_c = 0, m_jam = 0;
  int m_cr = 0, m_cc = 0, m_cr2 = 0, m_cc2 = 0;

  always @(posedge clk or negedge rst) begin : model
    bit s  [2];
    bit rq [2];
    bit sv [2];
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_p1[i] = 0; m_p2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
      end
      m_pend = 0; m_r = 0; m_c = 0; m_jam = 0;
      m_cr = 0; m_cc = 0; m_cr2 = 0; m_cc2 = 0;
    end else begin
      sv[0] = sens_r;
      sv[1] = sens_c;
      for (int i = 0; i < 2; i++) begin
        s[i]    = m_p2[i];
        m_p2[i] = m_p1[i];
        m_p1[i] = sv[i];
        rq[i]   = 0;
        if (s[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == N) begin
            m_lvl[i] = s[i];
            m_run[i] = 0;
            rq[i]    = s[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (rq[1]) m_pend++;
      m_r = rq[0];
      m_c = 0;
      if (!rq[0] && m_pend > 0) begin
        m_c = 1;
        m_pend--;
      end
      m_jam = m_lvl[0] && m_lvl[1];
      if (m_r) begin
        if (m_cr < 255) m_cr++;
        if (m_cr2 < 3) m_cr2++;
      end
      if (m_c) begin
        if (m_cc < 255) m_cc++;
        if (m_cc2 < 3) m_cc2++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge clk);
    chk("R", int'(r_o), int'(m_r));
    chk("C", int'(c_o), int'(m_c));
    chk("jam", int'(jam_o), int'(m_jam));
    chk("cnt_r", int'(cnt_r_o), m_cr);
    chk("cnt_c", int'(cnt_c_o), m_cc);
    chk("cnt_r_w2", int'(cnt_r2_o), m_cr2);
    chk("cnt_c_w2", int'(cnt_c2_o), m_cc2);
    chk("R2", int'(r2_o), int'(m_r));
    chk("C2", int'(c2_o), int'(m_c));
  endtask

  task automatic reset_dut();
    rst = 1'b0; sens_r = 1'b0; sens_c = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
  endtask

  int first_r, first_c, nr, nc;
  int exp_seq [5] = '{1, 2, 3, 3, 3};
  int seg_left[2] = '{0, 0};

  initial begin
    tick();
    chk("reset_R", int'(r_o), 0);
    chk("reset_cnt_r", int'(cnt_r_o), 0);
    reset_dut();

    // 1: single 1.00 coin, pulse on 6th edge after the first high sample.
    first_r = 0; nr = 0; nc = 0;
    sens_r = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (r_o && first_r == 0) first_r = k;
      nr += int'(r_o); nc += int'(c_o);
    end
    sens_r = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(); nr += int'(r_o); nc += int'(c_o);
    end
    chk("t1_latency", first_r, 6);
    chk("t1_pulses", nr, 1);
    chk("t1_no_c", nc, 0);
    chk("t1_cnt_r", int'(cnt_r_o), 1);

    // 2: toggling 0.50 sensor then steady high.
    reset_dut();
    nc = 0;
    for (int k = 0; k < 10; k++) begin
      sens_c = (k % 2 == 0);
      tick(); nc += int'(c_o);
    end
    sens_c = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(); nc += int'(c_o);
    end
    sens_c = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(); nc += int'(c_o);
    end
    chk("t2_pulses", nc, 1);
    chk("t2_cnt_c", int'(cnt_c_o), 1);

    // 3: both slots rise together.
    reset_dut();
    first_r = 0; first_c = 0;
    sens_r = 1'b1; sens_c = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (r_o && first_r == 0) first_r = k;
      if (c_o && first_c == 0) first_c = k;
      if (k == 10) chk("t3_jam_held", int'(jam_o), 1);
    end
    sens_r = 1'b0; sens_c = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("t3_r_at", first_r, 6);
    chk("t3_c_at", first_c, 7);
    chk("t3_jam_released", int'(jam_o), 0);
    chk("t3_cnt_r", int'(cnt_r_o), 1);
    chk("t3_cnt_c", int'(cnt_c_o), 1);

    // 4: short low gap while pressed.
    reset_dut();
    nr = 0;
    for (int k = 0; k < 32; k++) begin
      sens_r = (k < 10) || (k >= 12 && k < 22);
      tick(); nr += int'(r_o);
    end
    chk("t4_pulses", nr, 1);

    // 5: reset in the middle of DEB_HI with the sensor held.
    reset_dut();
    nc = 0;
    sens_c = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b0;
    tick();
    chk("t5_c_in_reset", int'(c_o), 0);
    tick();
    chk("t5_cnt_in_reset", int'(cnt_c_o), 0);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(); nc += int'(c_o);
    end
    sens_c = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(); nc += int'(c_o);
    end
    chk("t5_pulses", nc, 1);
    chk("t5_cnt_c", int'(cnt_c_o), 1);

    // 6: saturation of the 2-bit counter over five coins.
    reset_dut();
    nr = 0;
    for (int c = 0; c < 5; c++) begin
      sens_r = 1'b1;
      for (int k = 0; k < 8; k++) begin
        tick(); nr += int'(r2_o);
      end
      sens_r = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tick(); nr += int'(r2_o);
      end
      chk("t6_cnt_seq", int'(cnt_r2_o), exp_seq[c]);
    end
    chk("t6_pulses", nr, 5);

    // Random bouncy segments on both slots with occasional resets.
    reset_dut();
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (seg_left[i] == 0) begin
          seg_left[i] = int'($urandom_range(1, 10));
          if (i == 0) sens_r = ~sens_r;
          else sens_c = ~sens_c;
        end
        seg_left[i]--;
      end
      rst = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst = 1'b1; sens_r = 1'b0; sens_c = 1'b0;
    for (int k = 0; k < 20; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
